// File: rtl/r3l1_tx_pkg.sv
// Shared constants and state type for the R3/L1 readout-request transmitter.
package r3l1_tx_pkg;

  localparam int HDR_W     = 3;
  localparam int ID_W      = 8;
  localparam int FRAME_LEN = HDR_W + ID_W;

  localparam logic [HDR_W-1:0] R3_HDR = 3'b101;
  localparam logic [HDR_W-1:0] L1_HDR = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/r3l1_tx_channel.sv
// One serial request line: L0ID request queue, frame FSM and output shift register.
// A new frame may start from IDLE, or on the edge that ends the gap (or ends the
// frame when MIN_GAP is 0), so consecutive frames are exactly MIN_GAP zeros apart.
module r3l1_tx_channel
  import r3l1_tx_pkg::*;
#(
  parameter logic [HDR_W-1:0] HEADER     = R3_HDR,
  parameter int               FIFO_DEPTH = 4,
  parameter int               MIN_GAP    = 1
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            enable,
  input  logic            req,
  input  logic [ID_W-1:0] req_id,
  output logic            data_out,
  output logic            full,
  output logic            drop,
  output logic            quiet_next
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] GAP_INIT = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

  logic [ID_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  tx_state_t            state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic [FRAME_LEN-2:0] shreg_q, shreg_d;
  logic                 dout_q, dout_d;
  logic                 drop_q, drop_d;
  logic                 push, pop, can_start;
  logic [FRAME_LEN-1:0] frame;

  // Queue storage: written on accepted requests only.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= req_id;
  end

  // Next-state, queue bookkeeping and serial output selection.
  always_comb begin
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    push      = req & ~full;
    drop_d    = req & full;
    pop       = 1'b0;
    can_start = 1'b0;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shreg_d   = shreg_q;
    dout_d    = 1'b0;
    frame     = {HEADER, mem[rd_ptr_q]};

    unique case (state_q)
      IDLE: begin
        can_start = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt_q != 4'd0) begin
          dout_d    = shreg_q[FRAME_LEN-2];
          shreg_d   = {shreg_q[FRAME_LEN-3:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 4'd1;
        end else if (MIN_GAP == 0) begin
          // Last bit done and no gap wanted: act as IDLE on this edge.
          state_d   = IDLE;
          can_start = 1'b1;
        end else begin
          state_d   = GAP;
          gap_cnt_d = GAP_INIT;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d   = IDLE;
          can_start = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (can_start && enable && (count_q != '0)) begin
      pop       = 1'b1;
      dout_d    = frame[FRAME_LEN-1];
      shreg_d   = frame[FRAME_LEN-2:0];
      bit_cnt_d = 4'(FRAME_LEN - 1);
      state_d   = SHIFT;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    else                   count_d = count_q;

    quiet_next = (count_d == '0) && (state_d == IDLE);
  end

  // State registers; reset truncates any frame in flight.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shreg_q   <= '0;
      dout_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      drop_q    <= drop_d;
    end
  end

  assign data_out = dout_q;
  assign drop     = drop_q;

endmodule

// File: rtl/r3l1_cmd_transmitter.sv
// Two independent request-line transmitters (R3 and L1) plus the shared Idle flag.
module r3l1_cmd_transmitter
  import r3l1_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_GAP    = 1
) (
  input  logic            CLK,
  input  logic            SoftReset,
  input  logic            Enable,
  input  logic            R3Req,
  input  logic [ID_W-1:0] R3L0ID,
  input  logic            L1Req,
  input  logic [ID_W-1:0] L1L0ID,
  output logic            R3DataOut,
  output logic            L1DataOut,
  output logic            R3Full,
  output logic            L1Full,
  output logic            R3Drop,
  output logic            L1Drop,
  output logic            Idle
);

  logic r3_quiet_next, l1_quiet_next;
  logic idle_q, idle_d;

  r3l1_tx_channel #(.HEADER(R3_HDR), .FIFO_DEPTH(FIFO_DEPTH), .MIN_GAP(MIN_GAP)) u_r3 (
    .clk       (CLK),
    .srst      (SoftReset),
    .enable    (Enable),
    .req       (R3Req),
    .req_id    (R3L0ID),
    .data_out  (R3DataOut),
    .full      (R3Full),
    .drop      (R3Drop),
    .quiet_next(r3_quiet_next)
  );

  r3l1_tx_channel #(.HEADER(L1_HDR), .FIFO_DEPTH(FIFO_DEPTH), .MIN_GAP(MIN_GAP)) u_l1 (
    .clk       (CLK),
    .srst      (SoftReset),
    .enable    (Enable),
    .req       (L1Req),
    .req_id    (L1L0ID),
    .data_out  (L1DataOut),
    .full      (L1Full),
    .drop      (L1Drop),
    .quiet_next(l1_quiet_next)
  );

  // Idle reflects both channels' post-edge queue and FSM state.
  always_comb begin
    idle_d = r3_quiet_next & l1_quiet_next;
  end

  // Idle register; reset forces it high.
  always_ff @(posedge CLK) begin
    if (SoftReset) idle_q <= 1'b1;
    else           idle_q <= idle_d;
  end

  assign Idle = idle_q;

endmodule
